serial_word_shifter: RTL and testbench
======================================

Name: serial_word_shifter

Overview:
Upstream stage of the serial run-of-ones detector. It accepts parallel words through a valid/ready handshake and shifts each word out one bit at a time on the single-bit Data line, paced by an Enable bit strobe. After each word it drives an idle gap so the detector's run counter clears between words. Data is registered and feeds the detector's Data input directly, in the same Clock domain.

Parameters:
WIDTH, 8, bits per word; must be 2 or more.
MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
IDLE_LEVEL, 0, level driven on Data when no word is in flight; 0 forces the detector count to clear.
GAP_BITS, 1, number of Enable strobes of IDLE_LEVEL after each word; 0 means no gap.

Ports:
Clock  input  1  single clock; all state updates on posedge.
Reset  input  1  asynchronous, active-high; clears all state immediately.
Load_Data  input  WIDTH  parallel word; sampled only on the accepting edge.
Load_Valid  input  1  upstream offers Load_Data.
Load_Ready  output  1  block can accept a word; transfer occurs when Load_Valid && Load_Ready at posedge.
Enable  input  1  bit strobe; one bit period advances per posedge with Enable=1.
Data  output  1  serial bit to detector; registered.
Data_Valid  output  1  1 while Data carries a word bit.
Busy  output  1  1 in SHIFT or GAP.
Done  output  1  one-cycle pulse when the last bit period of a word ends.

Behaviour:
- Reset values, asynchronous: state IDLE, Data=IDLE_LEVEL, Data_Valid=0, Load_Ready=1, Busy=0, Done=0, shift register=0, bit counter=0, gap counter=0.
- Counters: bit counter is max($clog2(WIDTH),1) bits wide. Gap counter is max($clog2(GAP_BITS+1),1) bits wide. Neither counter wraps past its terminal value.
- State IDLE:
  - Load_Ready=1. Data=IDLE_LEVEL. Enable is ignored.
  - On Load_Valid at posedge: capture Load_Data, set bit counter to 0, go to SHIFT.
  - The first bit (MSB or LSB per MSB_FIRST) appears on Data after that same edge, with Data_Valid=1.
- State SHIFT:
  - Load_Ready=0. Load_Valid is ignored and Load_Data is not sampled.
  - Posedge with Enable=0: hold Data and counters.
  - Posedge with Enable=1 and bit counter < WIDTH-1: shift, present the next bit, increment bit counter.
  - Posedge with Enable=1 and bit counter == WIDTH-1: Done=1 for exactly one cycle, Data=IDLE_LEVEL, Data_Valid=0. Then go to GAP if GAP_BITS>0, else go to IDLE.
- State GAP:
  - Data=IDLE_LEVEL, Data_Valid=0, Load_Ready=0.
  - Count Enable strobes; after the GAP_BITS-th strobe edge, go to IDLE.
- Load_Ready is registered and equals (next state == IDLE). There are no back-to-back words without passing through IDLE.
- Latency with Enable held at 1: word accepted at edge k. Bit i is on Data after edge k+i, for i=0..WIDTH-1. Done=1 after edge k+WIDTH. Load_Ready returns after edge k+WIDTH+GAP_BITS.
- Busy = (state != IDLE). Done is never asserted together with Data_Valid.
- Reset mid-word or mid-gap: abort immediately to the reset values. No Done pulse; the partial word is discarded.
- If Load_Valid drops while Load_Ready=1: no transfer. Upstream must hold Load_Data stable only on the accepting edge.

Decomposition:
- Shared package serial_pkg:
  - state typedef enum {IDLE, SHIFT, GAP}.
  - Default constants for WIDTH, IDLE_LEVEL and GAP_BITS, shared with the detector bench.
- One natural sub-module: piso_shift_reg.
  - Parameters WIDTH and MSB_FIRST.
  - Ports: parallel load, shift enable, serial out.
  - Holds the datapath; the FSM and counters stay in the top.

Test Plan:
1. Reset, then load 8'hF0 with MSB_FIRST=1, GAP_BITS=1, Enable=1 -> Data after edges k..k+7 = 1,1,1,1,0,0,0,0; Done pulse after k+8; Load_Ready=1 after k+9.
2. Same word with MSB_FIRST=0 -> Data = 0,0,0,0,1,1,1,1, LSB first; Data_Valid=1 for exactly 8 cycles.
3. Enable toggling 1,0,1,0… (strobe every 2 cycles), load 8'hA5 -> each bit held 2 cycles; Done after 16 cycles; Load_Valid asserted during SHIFT with 8'hFF is ignored and its word never appears.
4. Load 8'hFF, GAP_BITS=2, chained into the detector -> detector count peaks at 8; Data=0 for 2 strobes after Done; the detector count returns to 0 before the next word.
5. Assert Reset asynchronously after bit 3 of 8'hC3 -> Data=IDLE_LEVEL and Load_Ready=1 immediately, with no Done pulse; a new word 8'h01 then serializes normally.
6. Load_Valid held high continuously with words 8'h81 then 8'h7E -> second word accepted only after GAP completes; exactly 2 Done pulses; no bit overlap between words.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word shifter and the run-of-ones
// detector that consumes its output.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int   DEF_WIDTH      = 8;
  localparam bit   DEF_MSB_FIRST  = 1'b1;
  localparam logic DEF_IDLE_LEVEL = 1'b0;
  localparam int   DEF_GAP_BITS   = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out datapath. The head bit of a newly loaded word is
// presented combinationally on first_bit so the caller can register it in the
// same edge; the register keeps only the bits still to be sent, and next_bit
// is the bit that goes out on the following shift.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             first_bit,
  output logic             next_bit
);

  logic [WIDTH-1:0] sreg_q, sreg_d;

  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit = load_data[WIDTH-1];
      assign next_bit  = sreg_q[WIDTH-1];
      // Remaining bits stay left-justified; each shift moves the next one to the top.
      always_comb begin
        sreg_d = sreg_q;
        if (load_en)       sreg_d = {load_data[WIDTH-2:0], 1'b0};
        else if (shift_en) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      end
    end else begin : g_lsb
      assign first_bit = load_data[0];
      assign next_bit  = sreg_q[0];
      // Remaining bits stay right-justified; each shift moves the next one to bit 0.
      always_comb begin
        sreg_d = sreg_q;
        if (load_en)       sreg_d = {1'b0, load_data[WIDTH-1:1]};
        else if (shift_en) sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      end
    end
  endgenerate

  // Datapath register, cleared asynchronously so an aborted word is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sreg_q <= '0;
    else     sreg_q <= sreg_d;
  end

endmodule

// File: rtl/serial_word_shifter.sv
// Serializes parallel words onto a single registered Data line, one bit per
// Enable strobe, followed by an idle gap so the downstream run counter clears.
module serial_word_shifter
  import serial_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter bit   MSB_FIRST  = DEF_MSB_FIRST,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL,
  parameter int   GAP_BITS   = DEF_GAP_BITS
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Load_Data,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  input  logic             Enable,
  output logic             Data,
  output logic             Data_Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            data_q, data_d;
  logic            data_valid_q, data_valid_d;
  logic            done_q, done_d;
  logic            load_ready_q;
  logic            busy_q;
  logic            load_en, shift_en;
  logic            first_bit, next_bit;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk       (Clock),
    .rst       (Reset),
    .load_en   (load_en),
    .load_data (Load_Data),
    .shift_en  (shift_en),
    .first_bit (first_bit),
    .next_bit  (next_bit)
  );

  // Next-state and next-output logic; Data holds unless a strobe moves it on.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    done_d       = 1'b0;
    load_en      = 1'b0;
    shift_en     = 1'b0;
    case (state_q)
      IDLE: begin
        data_d       = IDLE_LEVEL;
        data_valid_d = 1'b0;
        if (Load_Valid) begin
          load_en      = 1'b1;
          bit_cnt_d    = '0;
          data_d       = first_bit;
          data_valid_d = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (Enable) begin
          if (bit_cnt_q == BIT_LAST) begin
            done_d       = 1'b1;
            data_d       = IDLE_LEVEL;
            data_valid_d = 1'b0;
            gap_cnt_d    = '0;
            state_d      = (GAP_BITS > 0) ? GAP : IDLE;
          end else begin
            shift_en  = 1'b1;
            data_d    = next_bit;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      GAP: begin
        data_d       = IDLE_LEVEL;
        data_valid_d = 1'b0;
        if (Enable) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      default: begin
        state_d      = IDLE;
        data_d       = IDLE_LEVEL;
        data_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; ready/busy are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      data_q       <= IDLE_LEVEL;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      load_ready_q <= (state_d == IDLE);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign Data       = data_q;
  assign Data_Valid = data_valid_q;
  assign Done       = done_q;
  assign Load_Ready = load_ready_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: three instances share one stimulus stream
// (A: MSB first, gap 1; B: LSB first, gap 1; C: MSB first, gap 2). A
// scoreboard queue per instance holds the bits each accepted word must
// produce, and directed checks cover latency, handshake and reset behaviour.
module tb_serial_word_shifter;

  localparam bit [2:0] MSBF = 3'b101;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Load_Data;
  logic       Load_Valid;
  logic       Enable;
  logic [2:0] rdy, dat, dv, busy, done;

  int checks   = 0;
  int failures = 0;
  int dn_cnt [3];
  int dv_cyc [3];
  int run;
  int peak;
  int snap;
  int snap3 [3];
  logic [7:0] w;

  bit q0[$], q1[$], q2[$];

  always #5 Clock = ~Clock;

  serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP_BITS(1)) u_a (
    .Clock(Clock), .Reset(Reset), .Load_Data(Load_Data), .Load_Valid(Load_Valid),
    .Load_Ready(rdy[0]), .Enable(Enable), .Data(dat[0]), .Data_Valid(dv[0]),
    .Busy(busy[0]), .Done(done[0]));

  serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .GAP_BITS(1)) u_b (
    .Clock(Clock), .Reset(Reset), .Load_Data(Load_Data), .Load_Valid(Load_Valid),
    .Load_Ready(rdy[1]), .Enable(Enable), .Data(dat[1]), .Data_Valid(dv[1]),
    .Busy(busy[1]), .Done(done[1]));

  serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP_BITS(2)) u_c (
    .Clock(Clock), .Reset(Reset), .Load_Data(Load_Data), .Load_Valid(Load_Valid),
    .Load_Ready(rdy[2]), .Enable(Enable), .Data(dat[2]), .Data_Valid(dv[2]),
    .Busy(busy[2]), .Done(done[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic bit qfront(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0:       q0.delete(0);
      1:       q1.delete(0);
      default: q2.delete(0);
    endcase
  endtask

  task automatic push_word(input int i, input logic [7:0] wd);
    bit b;
    for (int j = 0; j < 8; j++) begin
      b = MSBF[i] ? wd[7-j] : wd[j];
      case (i)
        0:       q0.push_back(b);
        1:       q1.push_back(b);
        default: q2.push_back(b);
      endcase
    end
  endtask

  // Scoreboard: push on accepted handshake, pop when a bit period ends,
  // compare Data against the queue head mid-cycle, flush on reset.
  always @(posedge Clock or negedge Clock) begin
    if (Clock) begin
      if (!Reset) begin
        for (int i = 0; i < 3; i++) begin
          if (dv[i] && Enable && qsize(i) > 0) qpop(i);
          if (Load_Valid && rdy[i]) push_word(i, Load_Data);
        end
      end
    end else if (Reset) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (dv[i]) begin
          dv_cyc[i]++;
          chk($sformatf("sb_pending%0d", i), 32'(qsize(i) > 0), 1);
          if (qsize(i) > 0) chk($sformatf("sb_bit%0d", i), 32'(dat[i]), 32'(qfront(i)));
        end else begin
          chk($sformatf("idle_level%0d", i), 32'(dat[i]), 0);
        end
        chk($sformatf("done_with_valid%0d", i), 32'(done[i] && dv[i]), 0);
        if (done[i]) dn_cnt[i]++;
      end
    end
  end

  // Stand-in for the downstream run-of-ones counter, fed by instance C.
  always @(posedge Clock or posedge Reset) begin
    if (Reset)       run <= 0;
    else if (Enable) run <= dat[2] ? run + 1 : 0;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [7:0] wd);
    Load_Valid = 1'b1;
    Load_Data  = wd;
    tick();
    Load_Valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin dn_cnt[i] = 0; dv_cyc[i] = 0; end
    Reset = 1'b0; Enable = 1'b0; Load_Valid = 1'b0; Load_Data = '0;
    #1 Reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_data%0d", i),  32'(dat[i]),  0);
      chk($sformatf("rst_dv%0d", i),    32'(dv[i]),   0);
      chk($sformatf("rst_ready%0d", i), 32'(rdy[i]),  1);
      chk($sformatf("rst_busy%0d", i),  32'(busy[i]), 0);
      chk($sformatf("rst_done%0d", i),  32'(done[i]), 0);
    end
    #20 Reset = 1'b0;
    tick(); tick();

    // F0, Enable held high: MSB-first on A, LSB-first on B
    Enable = 1'b1;
    w = 8'hF0;
    snap = dv_cyc[1];
    load(w);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("t1_a_bit%0d", b), 32'(dat[0]), 32'(w[7-b]));
      chk($sformatf("t2_b_bit%0d", b), 32'(dat[1]), 32'(w[b]));
      chk($sformatf("t1_a_dv%0d", b),  32'(dv[0]),  1);
      if (b < 7) tick();
    end
    tick();
    chk("t1_a_done",  32'(done[0]), 1);
    chk("t1_a_dv_lo", 32'(dv[0]),   0);
    chk("t1_a_data",  32'(dat[0]),  0);
    chk("t1_a_rdy_gap", 32'(rdy[0]), 0);
    chk("t1_a_busy_gap", 32'(busy[0]), 1);
    chk("t1_c_done",  32'(done[2]), 1);
    tick();
    chk("t1_a_done_once", 32'(done[0]), 0);
    chk("t1_a_rdy_back",  32'(rdy[0]),  1);
    chk("t1_a_busy_lo",   32'(busy[0]), 0);
    chk("t1_c_rdy_gap2",  32'(rdy[2]),  0);
    tick();
    chk("t1_c_rdy_back",  32'(rdy[2]),  1);
    tick();
    chk("t2_b_dv_cycles", 32'(dv_cyc[1] - snap), 8);

    // A5 with a strobe every other cycle; an FF offered mid-word is ignored
    w = 8'hA5;
    load(w);
    for (int c = 1; c <= 16; c++) begin
      Enable = (c % 2 == 0);
      if (c == 3) begin Load_Valid = 1'b1; Load_Data = 8'hFF; end
      if (c == 11) Load_Valid = 1'b0;
      tick();
      if (c < 16) begin
        chk($sformatf("t3_a_bit_c%0d", c), 32'(dat[0]), 32'(w[7 - c/2]));
        chk($sformatf("t3_a_rdy_c%0d", c), 32'(rdy[0]), 0);
        chk($sformatf("t3_a_nodone_c%0d", c), 32'(done[0]), 0);
      end else begin
        chk("t3_a_done_16", 32'(done[0]), 1);
      end
    end
    Enable = 1'b1;
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 3; i++) chk($sformatf("t3_idle_rdy%0d", i), 32'(rdy[i]), 1);

    // FF into the run counter via C (gap of 2)
    load(8'hFF);
    peak = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (run > peak) peak = run;
      if (c == 8) chk("t4_c_done", 32'(done[2]), 1);
      if (c == 9) begin
        chk("t4_run_clear", 32'(run), 0);
        chk("t4_c_gap1_data", 32'(dat[2]), 0);
        chk("t4_c_gap1_rdy", 32'(rdy[2]), 0);
      end
      if (c == 10) begin
        chk("t4_c_gap2_data", 32'(dat[2]), 0);
        chk("t4_c_rdy_back", 32'(rdy[2]), 1);
      end
    end
    chk("t4_run_peak", 32'(peak), 8);

    // C3 aborted by reset after bit 3, then 01 goes through cleanly
    load(8'hC3);
    tick(); tick(); tick();
    snap = dn_cnt[0];
    #1 Reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_abort_dv%0d", i),   32'(dv[i]),   0);
      chk($sformatf("t5_abort_rdy%0d", i),  32'(rdy[i]),  1);
      chk($sformatf("t5_abort_busy%0d", i), 32'(busy[i]), 0);
      chk($sformatf("t5_abort_data%0d", i), 32'(dat[i]),  0);
    end
    #4 Reset = 1'b0;
    tick();
    chk("t5_no_done", 32'(done[0]), 0);
    chk("t5_idle_busy", 32'(busy[0]), 0);
    tick();
    chk("t5_no_done_count", 32'(dn_cnt[0] - snap), 0);
    w = 8'h01;
    load(w);
    for (int b = 1; b < 8; b++) tick();
    chk("t5_a_last_bit", 32'(dat[0]), 1);
    tick();
    chk("t5_a_done", 32'(done[0]), 1);
    tick(); tick(); tick();

    // Load_Valid held high across two words
    for (int i = 0; i < 3; i++) snap3[i] = dn_cnt[i];
    Load_Valid = 1'b1;
    Load_Data  = 8'h81;
    tick();
    Load_Data  = 8'h7E;
    for (int c = 1; c <= 9; c++) tick();
    chk("t6_a_rdy_k9", 32'(rdy[0]), 1);
    chk("t6_a_dv_k9",  32'(dv[0]),  0);
    chk("t6_c_rdy_k9", 32'(rdy[2]), 0);
    tick();
    chk("t6_a_dv_k10",   32'(dv[0]),  1);
    chk("t6_a_bit0_k10", 32'(dat[0]), 0);
    chk("t6_a_rdy_k10",  32'(rdy[0]), 0);
    chk("t6_c_rdy_k10",  32'(rdy[2]), 1);
    tick();
    chk("t6_c_dv_k11",   32'(dv[2]),  1);
    tick();
    Load_Valid = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("t6_two_done%0d", i), 32'(dn_cnt[i] - snap3[i]), 2);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sb_drained%0d", i), 32'(qsize(i)), 0);
      chk($sformatf("total_done%0d", i), 32'(dn_cnt[i]), 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
